// File: rtl/mips_dmem_bridge_if.sv
// Data-memory bridge bus: core MEM-stage port, external RAM port, LED and TX byte stream.
// Modports: slave (bridge side), master (environment side: core, RAM, consumer).
interface mips_dmem_bridge_if #(
    parameter int LED_W = 16
);
    logic             mem_ren;
    logic             mem_wen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_dout;
    logic [31:0]      mem_din;
    logic             ram_en;
    logic             ram_we;
    logic [29:0]      ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;
    logic [LED_W-1:0] led;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata, tx_ready,
        output mem_din, ram_en, ram_we, ram_addr, ram_wdata, led,
        output tx_valid, tx_data
    );

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata, tx_ready,
        input  mem_din, ram_en, ram_we, ram_addr, ram_wdata, led,
        input  tx_valid, tx_data
    );
endinterface

// File: rtl/mips_dmem_bridge.sv
// MEM-stage data bridge: routes accesses to RAM or MMIO (LED, TX FIFO, STATUS, CYCLE).
// Ports: clk, rst (async active-high), bus (slave). Macro CYCLE_CNT_EN enables CYCLE.
module mips_dmem_bridge #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         LED_W      = 16,
    parameter logic [3:0] MMIO_TAG   = 4'hF
) (
    input logic                 clk,
    input logic                 rst,
    mips_dmem_bridge_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic       wr, rd, mmio;
    logic [1:0] sel;

    assign wr   = bus.mem_wen & ~bus.mem_ren;
    assign rd   = bus.mem_ren;
    assign mmio = (bus.mem_addr[31:28] == MMIO_TAG);
    assign sel  = bus.mem_addr[3:2];

    // Byte offset bits carry no information for word accesses.
    logic unused_addr;
    assign unused_addr = ^bus.mem_addr[1:0];

    assign bus.ram_en    = (rd | wr) & ~mmio;
    assign bus.ram_we    = wr & ~mmio;
    assign bus.ram_addr  = bus.mem_addr[31:2];
    assign bus.ram_wdata = bus.mem_dout;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [LED_W-1:0] led_q, led_d;

    logic full, empty, pop, push_req, push_ok, ovf_clr;

    assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop      = ~empty & bus.tx_ready;
    assign push_req = wr & mmio & (sel == 2'd1);
    // A full FIFO still takes the byte if the head leaves this cycle.
    assign push_ok  = push_req & (~full | pop);
    assign ovf_clr  = wr & mmio & (sel == 2'd2) & bus.mem_dout[8];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        led_d    = led_q;
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok)
            wr_ptr_d = wr_ptr_q + PW'(1);
        unique case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        // Set beats clear when both happen together.
        if (ovf_clr)
            ovf_d = 1'b0;
        if (push_req & ~push_ok)
            ovf_d = 1'b1;
        if (wr & mmio & (sel == 2'd0))
            led_d = bus.mem_dout[LED_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            led_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            led_q    <= led_d;
        end
    end

    // Storage is not reset; the head is masked by tx_valid.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= bus.mem_dout[7:0];
    end

    assign bus.tx_valid = ~empty;
    assign bus.tx_data  = mem_q[rd_ptr_q];
    assign bus.led      = led_q;

    logic [31:0] cyc_val;

`ifdef CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic        cyc_wr;

    assign cyc_wr = wr & mmio & (sel == 2'd3);
    // A loaded value also counts the write edge itself.
    assign cyc_d  = (cyc_wr ? bus.mem_dout : cyc_q) + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cyc_q <= '0;
        else
            cyc_q <= cyc_d;
    end

    assign cyc_val = cyc_q;
`else
    assign cyc_val = '0;
`endif

    logic [3:0]  cnt4;
    logic [31:0] status, mmio_rdata;

    assign cnt4   = 4'(cnt_q);
    assign status = {23'd0, ovf_q, 2'd0, empty, full, cnt4};

    always_comb begin
        mmio_rdata = '0;
        unique case (sel)
            2'd0: mmio_rdata = 32'(led_q);
            2'd1: mmio_rdata = '0;
            2'd2: mmio_rdata = status;
            2'd3: mmio_rdata = cyc_val;
        endcase
    end

    assign bus.mem_din = rd ? (mmio ? mmio_rdata : bus.ram_rdata) : 32'd0;
endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Self-checking bench for mips_dmem_bridge: directed steps then random traffic
// compared against a queue-based reference model.
module tb_mips_dmem_bridge;
    localparam int DEPTH = 4;
    localparam int LW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_dmem_bridge_if #(.LED_W(LW)) bus();

    mips_dmem_bridge #(
        .FIFO_DEPTH(DEPTH),
        .LED_W(LW),
        .MMIO_TAG(4'hF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]    q[$];
    logic [LW-1:0] led_m;
    logic          ovf_m;
    logic [31:0]   cyc_m;
    logic [31:0]   din_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        led_m = '0;
        ovf_m = 1'b0;
        cyc_m = '0;
    endtask

    function automatic logic [31:0] cyc_exp();
`ifdef CYCLE_CNT_EN
        return cyc_m;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_din(input logic ren, input logic [31:0] a,
                                            input logic [31:0] rdata);
        logic [31:0] st;
        if (!ren) return 32'd0;
        if (a[31:28] != 4'hF) return rdata;
        st = 32'd0;
        st[3:0] = 4'(q.size());
        st[4]   = (q.size() == DEPTH);
        st[5]   = (q.size() == 0);
        st[8]   = ovf_m;
        case (a[3:2])
            2'd0: return 32'(led_m);
            2'd1: return 32'd0;
            2'd2: return st;
            default: return cyc_exp();
        endcase
    endfunction

    task automatic cyc(input logic ren, input logic wen, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rdata, input logic rdy);
        logic wr, mmio, pop, full, push, ld;
        bus.mem_ren   = ren;
        bus.mem_wen   = wen;
        bus.mem_addr  = a;
        bus.mem_dout  = d;
        bus.ram_rdata = rdata;
        bus.tx_ready  = rdy;
        #1;
        wr   = wen & ~ren;
        mmio = (a[31:28] == 4'hF);
        din_obs = bus.mem_din;
        chk("mem_din", bus.mem_din, exp_din(ren, a, rdata));
        chk("ram_en", 32'(bus.ram_en), 32'((ren | wr) & ~mmio));
        chk("ram_we", 32'(bus.ram_we), 32'(wr & ~mmio));
        chk("ram_addr", 32'(bus.ram_addr), {2'b00, a[31:2]});
        chk("ram_wdata", bus.ram_wdata, d);
        chk("led", 32'(bus.led), 32'(led_m));
        chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
        pop  = (q.size() != 0) && rdy;
        full = (q.size() == DEPTH);
        push = 1'b0;
        ld   = 1'b0;
        if (mmio && wr) begin
            case (a[3:2])
                2'd0: led_m = d[LW-1:0];
                2'd1: push = 1'b1;
                2'd2: if (d[8]) ovf_m = 1'b0;
                default: ld = 1'b1;
            endcase
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (!full || pop) q.push_back(d[7:0]);
            else ovf_m = 1'b1;
        end
`ifdef CYCLE_CNT_EN
        cyc_m = (ld ? d : cyc_m) + 32'd1;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_dout  = '0;
        bus.ram_rdata = '0;
        bus.tx_ready  = 1'b0;
        model_reset();
        #2;
        chk("rst_led", 32'(bus.led), 32'd0);
        chk("rst_txv", 32'(bus.tx_valid), 32'd0);
        bus.mem_ren  = 1'b1;
        bus.mem_addr = 32'hF000_0008;
        #1;
        chk("rst_status", bus.mem_din, 32'h20);
        bus.mem_addr = 32'hF000_000C;
        #1;
        chk("rst_cycle", bus.mem_din, 32'd0);
        bus.mem_ren = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        cyc(0, 1, 32'h40, 32'h1234ABCD, 0, 0);
        cyc(1, 0, 32'h40, 0, 32'hCAFEF00D, 0);
        chk("ram_read", din_obs, 32'hCAFEF00D);
        cyc(0, 1, 32'hF000_0000, 32'hFFFF5A5A, 0, 0);
        chk("led_val", 32'(bus.led), 32'h5A5A);
        cyc(1, 0, 32'hF000_0000, 0, 0, 0);
        chk("led_read", din_obs, 32'h5A5A);

        for (int i = 0; i < 4; i++)
            cyc(0, 1, 32'hF000_0004, 32'h41 + i, 0, 0);
        cyc(1, 0, 32'hF000_0008, 0, 0, 0);
        chk("status_full", din_obs, 32'h14);
        cyc(0, 1, 32'hF000_0004, 32'h45, 0, 0);
        cyc(1, 0, 32'hF000_0008, 0, 0, 0);
        chk("status_ovf", din_obs, 32'h114);
        for (int i = 0; i < 4; i++) begin
            chk("drain", 32'(bus.tx_data), 32'h41 + i);
            cyc(0, 0, 32'h0, 0, 0, 1);
        end
        cyc(1, 0, 32'hF000_0008, 0, 0, 0);
        chk("status_empty_ovf", din_obs, 32'h120);
        cyc(0, 1, 32'hF000_0008, 32'h100, 0, 0);
        cyc(1, 0, 32'hF000_0008, 0, 0, 0);
        chk("ovf_clear", din_obs, 32'h20);

        for (int i = 0; i < 4; i++)
            cyc(0, 1, 32'hF000_0004, 32'h61 + i, 0, 0);
        cyc(0, 1, 32'hF000_0004, 32'h55, 0, 1);
        cyc(1, 0, 32'hF000_0008, 0, 0, 0);
        chk("full_push_pop", din_obs, 32'h14);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] want;
            want = (i == 3) ? 8'h55 : 8'(8'h62 + i);
            chk("order", 32'(bus.tx_data), 32'(want));
            cyc(0, 0, 32'h0, 0, 0, 1);
        end

        cyc(0, 1, 32'hF000_000C, 32'hFFFF_FFFE, 0, 0);
        cyc(1, 0, 32'hF000_000C, 0, 0, 0);
`ifdef CYCLE_CNT_EN
        chk("cycle_load", din_obs, 32'hFFFF_FFFF);
`else
        chk("cycle_load", din_obs, 32'd0);
`endif
        cyc(1, 0, 32'hF000_000C, 0, 0, 0);
        chk("cycle_wrap", din_obs, 32'd0);

        cyc(1, 1, 32'hF000_0004, 32'h77, 0, 0);
        chk("rw_txdata", din_obs, 32'd0);
        cyc(1, 0, 32'hF000_0008, 0, 0, 0);
        chk("rw_nopush", din_obs, 32'h20);

        for (int i = 0; i < 3; i++)
            cyc(0, 1, 32'hF000_0004, 32'h11 * (i + 1), 0, 0);
        chk("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
        rst          = 1'b1;
        bus.mem_ren  = 1'b1;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = 32'hF000_0008;
        #1;
        chk("async_txv", 32'(bus.tx_valid), 32'd0);
        chk("async_status", bus.mem_din, 32'h20);
        chk("async_led", 32'(bus.led), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int          k;
            k = $urandom_range(0, 5);
            if (k == 0)
                a = $urandom() & 32'hEFFF_FFFC;
            else
                a = {4'hF, 24'($urandom()), (k == 5) ? 2'd1 : 2'(k - 1), 2'b00};
            cyc($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), a,
                $urandom(), $urandom(), $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_dmem_bridge.md
Name: mips_dmem_bridge

Overview:
- Sits directly downstream of the core's MEM-stage data interface (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).
- Decodes each access to either external data RAM or a small MMIO block: LED register, byte TX FIFO with valid/ready drain, and a free-running cycle counter.
- Read data returns in the same cycle, so the core's MEM stage never stalls.
- Write side effects land on the next rising clk edge.

Parameters:
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of 2, at least 2.
- LED_W, 16: width of LED output register, at most 32.
- MMIO_TAG, 4'hF: value of mem_addr[31:28] that selects the MMIO region.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- mem_ren  in  1  core data read enable.
- mem_wen  in  1  core data write enable.
- mem_addr  in  32  core byte address, word-aligned.
- mem_dout  in  32  write data from core.
- mem_din  out  32  read data to core, combinational.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  30  RAM word address (mem_addr[31:2]).
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, asynchronous read.
- led  out  LED_W  LED register.
- tx_valid  out  1  FIFO head valid.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts head this cycle.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high; it clears all state immediately, independent of clk.
- Effective write: wr = mem_wen & ~mem_ren. Effective read: rd = mem_ren.
- Region select: mmio = (mem_addr[31:28] == MMIO_TAG); otherwise the access goes to RAM.
- RAM path, purely combinational:
  - ram_en = (rd | wr) & ~mmio; ram_we = wr & ~mmio.
  - ram_addr = mem_addr[31:2]; ram_wdata = mem_dout.
- MMIO map, decoded on mem_addr[3:2]; mem_addr[27:4] ignored (aliases):
  - 0x0 LED: R/W. Write loads mem_dout[LED_W-1:0]. Read returns zero-extended led.
  - 0x4 TXDATA: W pushes mem_dout[7:0]. Reads return 0.
  - 0x8 STATUS: read-only fields.
    - [3:0] count (zero-extended).
    - [4] full; [5] empty.
    - [8] overflow, sticky.
    - Writing with mem_dout[8]=1 clears overflow; other bits ignored.
  - 0xC CYCLE: 32-bit counter, +1 every clk, wraps 0xFFFFFFFF->0. Write loads mem_dout; the counter shows mem_dout+1 one cycle later.
- mem_din:
  - ram_rdata when rd & ~mmio.
  - MMIO register value when rd & mmio.
  - 0 otherwise (no read).
- TX FIFO:
  - Circular buffer with rd_ptr/wr_ptr of log2(FIFO_DEPTH) bits plus a count register (0..FIFO_DEPTH).
  - tx_valid = (count != 0); tx_data = buf[rd_ptr].
  - pop = tx_valid & tx_ready; push_req = wr & mmio & TXDATA.
  - Push accepted if count < FIFO_DEPTH, or if full and pop occurs the same cycle.
  - Rejected push: byte dropped, overflow set to 1, FIFO unchanged.
  - Push and pop together: count unchanged, both pointers advance.
  - Pop while empty: impossible, because tx_valid = 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow set and clear in the same cycle: set wins.
- Reset values:
  - led=0, tx_valid=0, tx_data=buf[0] (buffer contents not reset; tx_data is don't-care while tx_valid=0).
  - count=0, pointers=0, overflow=0, cycle=0.
  - mem_din/ram_* follow inputs combinationally.
- Reset asserted mid-operation: FIFO contents are discarded and tx_valid drops immediately, asynchronously.

Optional Feature:
- CYCLE_CNT_EN defined: CYCLE register present as described.
- Not defined: no counter flops; CYCLE reads 0 and writes to it are ignored; all other behaviour identical.

Test Plan:
- After rst: write 0x1234ABCD to 0x00000040 -> ram_en=1, ram_we=1, ram_addr=0x10, ram_wdata=0x1234ABCD. Read same address with ram_rdata=0xCAFEF00D -> mem_din=0xCAFEF00D in the same cycle, no MMIO state change.
- Write 0xFFFF5A5A to 0xF0000000 -> led=0x5A5A next edge, ram_en=0. Read 0xF0000000 -> mem_din=0x00005A5A.
- tx_ready=0; push 0x41,0x42,0x43,0x44,0x45 -> STATUS reads 0x14 (count 4, full) after the 4th push, 0x114 after the 5th (overflow). Set tx_ready=1 -> tx_data sequence 0x41..0x44, then STATUS=0x120. Write 0x100 to STATUS -> reads 0x20.
- FIFO full, tx_ready=1, push 0x55 in the same cycle -> accepted, overflow stays 0, count stays 4; 0x55 emerges 4th after the pop.
- CYCLE_CNT_EN defined: write 0xFFFFFFFE to 0xF000000C -> reads 0xFFFFFFFF next cycle, 0x00000000 the cycle after (wrap). Undefined: reads 0.
- With the FIFO holding 3 bytes, assert rst between clock edges -> tx_valid=0 and STATUS=0x20 immediately, before the next edge.
- mem_ren=1 and mem_wen=1 to 0xF0000004 -> no push, mem_din=0.
